// File: rtl/mult_div_unit_if.sv
// Handshake and result bus between the multicycle control unit and the
// iterative multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic                    MultCtrl;
  logic                    DivCtrl;
  logic signed [WIDTH-1:0] A;
  logic signed [WIDTH-1:0] B;
  logic        [WIDTH-1:0] HI;
  logic        [WIDTH-1:0] LO;
  logic                    Busy;
  logic                    Done;
  logic                    DivZero;

  modport master (
    output MultCtrl, DivCtrl, A, B,
    input  HI, LO, Busy, Done, DivZero
  );

  modport slave (
    input  MultCtrl, DivCtrl, A, B,
    output HI, LO, Busy, Done, DivZero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and restoring divide feeding HI/LO.
// One iteration per cycle, WIDTH iterations per operation.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  // Booth accumulator / division remainder; one guard bit keeps -2^(W-1) from overflowing
  logic signed [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]        mpl_q, mpl_d;
  logic                    booth_q, booth_d;
  logic [WIDTH-1:0]        opnd_q, opnd_d;
  logic                    negq_q, negq_d;
  logic                    negr_q, negr_d;
  logic [WIDTH-1:0]        hi_q, hi_d;
  logic [WIDTH-1:0]        lo_q, lo_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    divzero_q, divzero_d;

  logic signed [WIDTH:0]   mcand_x;
  logic signed [WIDTH:0]   booth_sum;
  logic        [WIDTH:0]   rem_sh;
  logic        [WIDTH:0]   rem_diff;

  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return neg_if(v[WIDTH-1], v);
  endfunction

  always_comb begin
    mcand_x = $signed({opnd_q[WIDTH-1], opnd_q});
    case ({mpl_q[0], booth_q})
      2'b01:   booth_sum = acc_q + mcand_x;
      2'b10:   booth_sum = acc_q - mcand_x;
      default: booth_sum = acc_q;
    endcase
    rem_sh   = {acc_q[WIDTH-1:0], mpl_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mpl_d     = mpl_q;
    booth_d   = booth_q;
    opnd_d    = opnd_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.MultCtrl) begin
          state_d = MULT;
          cnt_d   = CNT_W'(WIDTH - 1);
          acc_d   = '0;
          mpl_d   = bus.B;
          booth_d = 1'b0;
          opnd_d  = bus.A;
          busy_d  = 1'b1;
        end else if (bus.DivCtrl) begin
          if (bus.B != '0) begin
            state_d = DIV;
            cnt_d   = CNT_W'(WIDTH - 1);
            acc_d   = '0;
            mpl_d   = mag(bus.A);
            booth_d = 1'b0;
            opnd_d  = mag(bus.B);
            negq_d  = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            negr_d  = bus.A[WIDTH-1];
            busy_d  = 1'b1;
          end else begin
            divzero_d = 1'b1;
          end
        end
      end

      MULT: begin
        acc_d            = booth_sum >>> 1;
        {mpl_d, booth_d} = {booth_sum[0], mpl_q};
        cnt_d            = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          cnt_d   = '0;
          hi_d    = acc_d[WIDTH-1:0];
          lo_d    = mpl_d;
          done_d  = 1'b1;
        end
      end

      DIV: begin
        // Quotient bits shift in at the bottom of mpl as the dividend shifts out the top
        if (!rem_diff[WIDTH]) begin
          acc_d = $signed({1'b0, rem_diff[WIDTH-1:0]});
          mpl_d = {mpl_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = $signed({1'b0, rem_sh[WIDTH-1:0]});
          mpl_d = {mpl_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          cnt_d   = '0;
          lo_d    = neg_if(negq_q, mpl_d);
          hi_d    = neg_if(negr_q, acc_d[WIDTH-1:0]);
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mpl_q     <= '0;
      booth_q   <= 1'b0;
      opnd_q    <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mpl_q     <= mpl_d;
      booth_q   <= booth_d;
      opnd_q    <= opnd_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DivZero = divzero_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, reset-abort sequence and
// randomized operations against a plain-arithmetic reference model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus();
  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         m;
    logic         d;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           poke;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: MIPS semantics straight from 64-bit integer arithmetic
  function automatic void model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo,
                                output logic dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    dz = 1'b0;
    if (m) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endfunction

  // Called just after a rising edge; the request occupies the following cycle T.
  task automatic do_op(input string name, input logic m, input logic d,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic ez, input int poke);
    logic [W-1:0] pre_hi, pre_lo, got_hi, got_lo;
    int done_at, n_done, n_dz, busy_bad;
    pre_hi = bus.HI;
    pre_lo = bus.LO;
    bus.MultCtrl = m;
    bus.DivCtrl  = d;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk); #1;
    bus.MultCtrl = 1'b0;
    bus.DivCtrl  = 1'b0;
    bus.A        = $urandom;
    bus.B        = $urandom;
    if (ez) begin
      chk({name, ".divzero_t1"}, 64'(bus.DivZero), 64'd1);
      chk({name, ".busy_t1"},    64'(bus.Busy),    64'd0);
      @(posedge clk); #1;
      chk({name, ".divzero_t2"}, 64'(bus.DivZero), 64'd0);
      chk({name, ".done"},       64'(bus.Done),    64'd0);
      chk({name, ".hi_kept"},    64'(bus.HI),      64'(pre_hi));
      chk({name, ".lo_kept"},    64'(bus.LO),      64'(pre_lo));
    end else begin
      done_at  = 0;
      n_done   = 0;
      n_dz     = 0;
      busy_bad = 0;
      got_hi   = '0;
      got_lo   = '0;
      for (int k = 1; k <= W + 4; k++) begin
        if (bus.Done) begin
          n_done++;
          if (done_at == 0) begin
            done_at = k;
            got_hi  = bus.HI;
            got_lo  = bus.LO;
          end
        end
        if (bus.DivZero) n_dz++;
        if ((k <= W + 1) != bus.Busy) busy_bad++;
        if (poke != 0 && k == poke) begin
          bus.DivCtrl  = 1'b1;
          bus.MultCtrl = 1'b1;
          bus.B        = '0;
        end else begin
          bus.DivCtrl  = 1'b0;
          bus.MultCtrl = 1'b0;
        end
        @(posedge clk); #1;
      end
      chk({name, ".done_cycle"}, 64'(done_at),  64'(W + 1));
      chk({name, ".done_count"}, 64'(n_done),   64'd1);
      chk({name, ".divzero"},    64'(n_dz),     64'd0);
      chk({name, ".busy_bad"},   64'(busy_bad), 64'd0);
      chk({name, ".hi"},         64'(got_hi),   64'(eh));
      chk({name, ".lo"},         64'(got_lo),   64'(el));
      chk({name, ".hi_hold"},    64'(bus.HI),   64'(eh));
      chk({name, ".lo_hold"},    64'(bus.LO),   64'(el));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb, eh, el;
    logic         rm, ez;
    int           t, n_done, n_busy, n_dz;

    vecs[0]  = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b1, 32'd5,        32'd0,        32'h0,        32'h0,        1'b1, 0};
    vecs[3]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 0};
    vecs[4]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0, 0};
    vecs[5]  = '{1'b1, 1'b1, 32'd3,        32'd4,        32'h0,        32'd12,       1'b0, 5};
    vecs[6]  = '{1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 0};
    vecs[7]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 0};
    vecs[8]  = '{1'b0, 1'b1, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0, 0};
    vecs[9]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'd1,        1'b0, 0};
    vecs[10] = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 0};
    vecs[11] = '{1'b0, 1'b1, 32'd3,        32'd10,       32'd3,        32'h0,        1'b0, 0};
    vecs[12] = '{1'b1, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, 1'b0, 0};

    reset        = 1'b1;
    bus.MultCtrl = 1'b0;
    bus.DivCtrl  = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset.hi",      64'(bus.HI),      64'd0);
    chk("reset.lo",      64'(bus.LO),      64'd0);
    chk("reset.busy",    64'(bus.Busy),    64'd0);
    chk("reset.done",    64'(bus.Done),    64'd0);
    chk("reset.divzero", 64'(bus.DivZero), 64'd0);

    for (int i = 0; i < 13; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
            vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].poke);
    end

    // Reset in cycle T+10 of a multiply aborts it with no Done
    bus.MultCtrl = 1'b1;
    bus.A        = 32'd7;
    bus.B        = 32'd9;
    @(posedge clk); #1;
    bus.MultCtrl = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort.busy", 64'(bus.Busy), 64'd0);
    chk("abort.hi",   64'(bus.HI),   64'd0);
    chk("abort.lo",   64'(bus.LO),   64'd0);
    chk("abort.done", 64'(bus.Done), 64'd0);
    n_done = 0;
    n_busy = 0;
    n_dz   = 0;
    for (int k = 0; k < W + 4; k++) begin
      if (bus.Done) n_done++;
      if (bus.Busy) n_busy++;
      if (bus.DivZero) n_dz++;
      @(posedge clk); #1;
    end
    chk("abort.late_done", 64'(n_done), 64'd0);
    chk("abort.late_busy", 64'(n_busy), 64'd0);
    chk("abort.late_dz",   64'(n_dz),   64'd0);
    do_op("after_abort", 1'b1, 1'b0, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        t  = int'($urandom_range(0, 20)) - 10;
        rb = t;
      end
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      model(rm, ra, rb, eh, el, ez);
      do_op($sformatf("rand%0d", i), rm, ~rm, ra, rb, eh, el, ez, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
